// File: rtl/axc_mult_err_monitor.sv
// On-chip error characterisation of a constant-multiplier stream: recomputes inp*COEFF
// for each accepted pair and accumulates count, mismatches, saturating |err| sum and max |err|.
module axc_mult_err_monitor #(
  parameter int BIT_WIDTH = 5,
  parameter int OUT_WIDTH = BIT_WIDTH + 8,
  parameter int COEFF     = 100,
  parameter int CNT_WIDTH = 17,
  parameter int ACC_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_samples,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] inp,
  input  logic [OUT_WIDTH-1:0] out,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] sample_cnt,
  output logic [CNT_WIDTH-1:0] mismatch_cnt,
  output logic [ACC_WIDTH-1:0] sum_abs_err,
  output logic [OUT_WIDTH:0]   max_abs_err,
  output logic                 acc_sat
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int EW   = OUT_WIDTH + 1;
  localparam int SUMW = ((ACC_WIDTH > EW) ? ACC_WIDTH : EW) + 1;
  localparam logic signed [EW-1:0] L_COEFF   = EW'(COEFF);
  localparam logic [SUMW-1:0]      L_ACC_MAX = {{(SUMW-ACC_WIDTH){1'b0}}, {ACC_WIDTH{1'b1}}};

  logic [1:0]           r_state;
  logic [CNT_WIDTH-1:0] r_num;
  logic [CNT_WIDTH-1:0] r_accepted;
  logic                 r_v1;
  logic [EW-1:0]        r_abs1;
  logic                 r_mis1;

  logic signed [EW-1:0] w_inp_x, w_out_x, w_exact, w_err;
  logic [EW-1:0]        w_abs;
  logic [SUMW-1:0]      w_sum_ext;
  logic                 w_xfer;

  assign in_ready = (r_state == S_RUN) && (r_accepted < r_num);
  assign busy     = (r_state == S_RUN);
  assign done     = (r_state == S_DONE);
  assign w_xfer   = in_valid && in_ready;

  assign w_inp_x   = {{(EW-BIT_WIDTH){inp[BIT_WIDTH-1]}}, inp};
  assign w_out_x   = {out[OUT_WIDTH-1], out};
  assign w_exact   = w_inp_x * L_COEFF;
  assign w_err     = w_out_x - w_exact;
  assign w_abs     = w_err[EW-1] ? EW'(-w_err) : EW'(w_err);
  // Wide enough that a single add can never wrap before the saturation compare.
  assign w_sum_ext = SUMW'(sum_abs_err) + SUMW'(r_abs1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_num        <= '0;
      r_accepted   <= '0;
      r_v1         <= 1'b0;
      r_abs1       <= '0;
      r_mis1       <= 1'b0;
      sample_cnt   <= '0;
      mismatch_cnt <= '0;
      sum_abs_err  <= '0;
      max_abs_err  <= '0;
      acc_sat      <= 1'b0;
    end else begin
      r_v1 <= w_xfer;
      if (w_xfer) begin
        r_abs1     <= w_abs;
        r_mis1     <= |w_abs;
        r_accepted <= r_accepted + 1'b1;
      end
      if (r_v1) begin
        sample_cnt   <= sample_cnt + 1'b1;
        mismatch_cnt <= mismatch_cnt + CNT_WIDTH'(r_mis1);
        if (r_abs1 > max_abs_err) max_abs_err <= r_abs1;
        if (w_sum_ext > L_ACC_MAX) begin
          sum_abs_err <= '1;
          acc_sat     <= 1'b1;
        end else begin
          sum_abs_err <= w_sum_ext[ACC_WIDTH-1:0];
        end
      end
      // Last sample's stage 2 lands on the same edge as RUN->DONE, so no extra drain cycle.
      case (r_state)
        S_IDLE, S_DONE: if (start) begin
          r_state      <= S_RUN;
          r_num        <= num_samples;
          r_accepted   <= '0;
          sample_cnt   <= '0;
          mismatch_cnt <= '0;
          sum_abs_err  <= '0;
          max_abs_err  <= '0;
          acc_sat      <= 1'b0;
        end
        S_RUN: if (r_accepted == r_num) r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axc_mult_err_monitor.sv
// Directed bench for axc_mult_err_monitor; a second instance with an 8-bit accumulator covers saturation.
module tb_axc_mult_err_monitor;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [16:0] num_samples = '0;
  logic        in_valid = 1'b0;
  logic [4:0]  inp = '0;
  logic [12:0] out = '0;

  logic        in_ready, busy, done, acc_sat;
  logic [16:0] sample_cnt, mismatch_cnt;
  logic [31:0] sum_abs_err;
  logic [13:0] max_abs_err;

  logic        s_in_ready, s_busy, s_done, s_acc_sat;
  logic [16:0] s_sample_cnt, s_mismatch_cnt;
  logic [7:0]  s_sum_abs_err;
  logic [13:0] s_max_abs_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axc_mult_err_monitor dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .inp(inp), .out(out),
    .busy(busy), .done(done), .sample_cnt(sample_cnt), .mismatch_cnt(mismatch_cnt),
    .sum_abs_err(sum_abs_err), .max_abs_err(max_abs_err), .acc_sat(acc_sat)
  );

  axc_mult_err_monitor #(.ACC_WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(s_in_ready), .inp(inp), .out(out),
    .busy(s_busy), .done(s_done), .sample_cnt(s_sample_cnt), .mismatch_cnt(s_mismatch_cnt),
    .sum_abs_err(s_sum_abs_err), .max_abs_err(s_max_abs_err), .acc_sat(s_acc_sat)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input int n);
    start = 1'b1; num_samples = 17'(n);
    tick();
    start = 1'b0;
  endtask

  // Holds the pair until it is taken; leaves in_valid high for back-to-back use.
  task automatic send(input int a, input int b);
    bit ok = 0;
    in_valid = 1'b1; inp = 5'(a); out = 13'(b);
    for (int i = 0; i < 20 && !ok; i++) begin
      if (in_ready) ok = 1;
      tick();
    end
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL send_timeout in_ready=%0b required 1", in_ready); end
  endtask

  task automatic wait_done();
    int i = 0;
    while (!done && i < 50) begin tick(); i++; end
    n_tests++;
    if (!done) begin n_fail++; $display("FAIL wait_done done=%0b required 1", done); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick(); tick();
    n_tests++;
    if ({in_ready, busy, done, acc_sat} !== 4'b0 || sample_cnt !== 0 || mismatch_cnt !== 0 ||
        sum_abs_err !== 0 || max_abs_err !== 0) begin
      n_fail++; $display("FAIL reset_state rdy=%0b busy=%0b done=%0b cnt=%0d required all 0",
                         in_ready, busy, done, sample_cnt);
    end
    rst_n = 1'b1; tick();
    n_tests++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset busy=%0b rdy=%0b required 0 0", busy, in_ready);
    end
  endtask

  task automatic test_exact();
    do_start(3);
    n_tests++;
    if (busy !== 1'b1 || done !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL exact_run_entry busy=%0b done=%0b rdy=%0b required 1 0 1", busy, done, in_ready);
    end
    send(3, 300); send(-16, -1600); send(15, 1500);
    in_valid = 1'b0;
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL exact_latency_k done=%0b busy=%0b required 0 1", done, busy);
    end
    tick();
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL exact_latency_k1 done=%0b busy=%0b required 1 0", done, busy);
    end
    n_tests++;
    if (sample_cnt !== 3 || mismatch_cnt !== 0 || sum_abs_err !== 0 || max_abs_err !== 0) begin
      n_fail++; $display("FAIL exact_stats cnt=%0d mis=%0d sum=%0d max=%0d required 3 0 0 0",
                         sample_cnt, mismatch_cnt, sum_abs_err, max_abs_err);
    end
  endtask

  task automatic test_error_accum();
    do_start(3);
    send(15, 1490); send(-16, -1590); send(1, 103);
    in_valid = 1'b0;
    wait_done();
    n_tests++;
    if (sample_cnt !== 3 || mismatch_cnt !== 3 || sum_abs_err !== 23 || max_abs_err !== 10) begin
      n_fail++; $display("FAIL err_stats cnt=%0d mis=%0d sum=%0d max=%0d required 3 3 23 10",
                         sample_cnt, mismatch_cnt, sum_abs_err, max_abs_err);
    end
    tick(); tick();
    n_tests++;
    if (done !== 1'b1 || sum_abs_err !== 23) begin
      n_fail++; $display("FAIL err_hold done=%0b sum=%0d required 1 23", done, sum_abs_err);
    end
  endtask

  task automatic test_backpressure();
    int xfers = 0;
    do_start(2);
    in_valid = 1'b1; inp = 5'd1; out = 13'd100;
    for (int i = 0; i < 5; i++) begin
      if (in_ready) xfers++;
      tick();
    end
    in_valid = 1'b0;
    n_tests++;
    if (xfers !== 2 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_transfers xfers=%0d rdy=%0b required 2 0", xfers, in_ready);
    end
    n_tests++;
    if (sample_cnt !== 2 || done !== 1'b1) begin
      n_fail++; $display("FAIL bp_cnt cnt=%0d done=%0b required 2 1", sample_cnt, done);
    end
    // Gaps mid-run plus a start pulse while busy, which must be ignored.
    do_start(3);
    send(2, 201);
    in_valid = 1'b0;
    tick();
    start = 1'b1; num_samples = 17'd7; tick(); start = 1'b0;
    tick();
    n_tests++;
    if (sample_cnt !== 1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL gap_mid cnt=%0d busy=%0b required 1 1", sample_cnt, busy);
    end
    send(2, 200); send(-2, -205);
    in_valid = 1'b0;
    wait_done();
    n_tests++;
    if (sample_cnt !== 3 || mismatch_cnt !== 2 || sum_abs_err !== 6 || max_abs_err !== 5) begin
      n_fail++; $display("FAIL gap_stats cnt=%0d mis=%0d sum=%0d max=%0d required 3 2 6 5",
                         sample_cnt, mismatch_cnt, sum_abs_err, max_abs_err);
    end
  endtask

  task automatic test_zero_restart();
    do_start(0);
    n_tests++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || sample_cnt !== 0) begin
      n_fail++; $display("FAIL zero_run busy=%0b rdy=%0b cnt=%0d required 1 0 0", busy, in_ready, sample_cnt);
    end
    tick();
    n_tests++;
    if (done !== 1'b1 || sample_cnt !== 0 || mismatch_cnt !== 0 || sum_abs_err !== 0 || max_abs_err !== 0) begin
      n_fail++; $display("FAIL zero_done done=%0b cnt=%0d sum=%0d required 1 0 0", done, sample_cnt, sum_abs_err);
    end
    do_start(1);
    send(-1, -90);
    in_valid = 1'b0;
    wait_done();
    n_tests++;
    if (sample_cnt !== 1 || mismatch_cnt !== 1 || sum_abs_err !== 10 || max_abs_err !== 10) begin
      n_fail++; $display("FAIL restart_stats cnt=%0d mis=%0d sum=%0d max=%0d required 1 1 10 10",
                         sample_cnt, mismatch_cnt, sum_abs_err, max_abs_err);
    end
  endtask

  task automatic test_saturation();
    do_start(30);
    for (int i = 0; i < 30; i++) send(0, 10);
    in_valid = 1'b0;
    wait_done();
    n_tests++;
    if (s_sum_abs_err !== 8'd255 || s_acc_sat !== 1'b1 || s_sample_cnt !== 30) begin
      n_fail++; $display("FAIL sat_acc8 sum=%0d sat=%0b cnt=%0d required 255 1 30",
                         s_sum_abs_err, s_acc_sat, s_sample_cnt);
    end
    n_tests++;
    if (sum_abs_err !== 300 || acc_sat !== 1'b0) begin
      n_fail++; $display("FAIL sat_acc32 sum=%0d sat=%0b required 300 0", sum_abs_err, acc_sat);
    end
    do_start(1);
    n_tests++;
    if (s_acc_sat !== 1'b0 || s_sum_abs_err !== 0) begin
      n_fail++; $display("FAIL sat_clear sat=%0b sum=%0d required 0 0", s_acc_sat, s_sum_abs_err);
    end
    send(0, 0);
    in_valid = 1'b0;
    wait_done();
  endtask

  task automatic test_reset_midrun();
    do_start(5);
    send(1, 104); send(3, 290);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({in_ready, busy, done, acc_sat} !== 4'b0 || sample_cnt !== 0 || mismatch_cnt !== 0 ||
        sum_abs_err !== 0 || max_abs_err !== 0) begin
      n_fail++; $display("FAIL async_reset rdy=%0b busy=%0b cnt=%0d sum=%0d required all 0",
                         in_ready, busy, sample_cnt, sum_abs_err);
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || sample_cnt !== 0) begin
      n_fail++; $display("FAIL post_reset_idle busy=%0b done=%0b cnt=%0d required 0 0 0", busy, done, sample_cnt);
    end
    do_start(1);
    send(2, 200);
    in_valid = 1'b0;
    wait_done();
    n_tests++;
    if (sample_cnt !== 1 || mismatch_cnt !== 0 || sum_abs_err !== 0) begin
      n_fail++; $display("FAIL post_reset_run cnt=%0d mis=%0d sum=%0d required 1 0 0",
                         sample_cnt, mismatch_cnt, sum_abs_err);
    end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_error_accum();
    test_backpressure();
    test_zero_restart();
    test_saturation();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
